// File: rtl/wb_nor_multibus.sv
// wb_nor_multibus
//   Wishbone (pipelined, single outstanding request) bridge to several
//   asynchronous NOR flash chips sharing address, data, OE# and WE#.
//   Each access waits for the selected chip's ready line, then runs a
//   SETUP / STROBE / HOLD pin sequence with programmable cycle counts.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wb_adr_i                  {chip index, word address}
//   wb_dat_i, wb_we_i         write data / write enable
//   wb_cyc_i, wb_stb_i        Wishbone cycle / strobe
//   wb_err_i                  master abort
//   wb_ack_o, wb_stall_o      Wishbone handshake
//   wb_dat_o                  read data (all ones on timeout / bad chip)
//   timeout_o                 sticky ready-wait timeout flag
//   nor_ry_i                  per-chip ready/busy#, 1 = ready
//   nor_data_i/o, nor_data_oe shared data bus (oe = 1 drives the bus)
//   nor_addr_o                shared word address
//   nor_ce_o                  per-chip chip enable, active low
//   nor_oe_o, nor_we_o        shared output / write enable, active low
module wb_nor_multibus #(
   parameter int ADDRBITS   = 26,
   parameter int DATABITS   = 16,
   parameter int NCHIPS     = 2,
   parameter int TSETUP     = 1,
   parameter int TSTRB_RD   = 7,
   parameter int TSTRB_WR   = 4,
   parameter int THOLD      = 1,
   parameter int RY_TIMEOUT = 1024,
   localparam int CSBITS    = (NCHIPS > 1) ? $clog2(NCHIPS) : 1
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic [ADDRBITS+CSBITS-1:0] wb_adr_i,
   input  logic [DATABITS-1:0]        wb_dat_i,
   input  logic                       wb_we_i,
   input  logic                       wb_cyc_i,
   input  logic                       wb_stb_i,
   input  logic                       wb_err_i,
   output logic                       wb_ack_o,
   output logic                       wb_stall_o,
   output logic [DATABITS-1:0]        wb_dat_o,
   output logic                       timeout_o,
   input  logic [NCHIPS-1:0]          nor_ry_i,
   input  logic [DATABITS-1:0]        nor_data_i,
   output logic [DATABITS-1:0]        nor_data_o,
   output logic                       nor_data_oe,
   output logic [ADDRBITS-1:0]        nor_addr_o,
   output logic [NCHIPS-1:0]          nor_ce_o,
   output logic                       nor_oe_o,
   output logic                       nor_we_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_RYWAIT, S_SETUP, S_STROBE, S_HOLD, S_ACK
   } state_t;

   state_t                state, state_nxt;
   logic [31:0]           cnt, cnt_nxt;
   logic [31:0]           strb_last;
   logic [ADDRBITS-1:0]   adr_q;
   logic [CSBITS-1:0]     chip_q;
   logic [CSBITS-1:0]     wb_chip;
   logic [DATABITS-1:0]   dat_q;
   logic                  we_q;
   logic                  accept, abort, chip_ok;
   logic                  capture, tmo_hit;
   logic                  ry_sel;
   logic [NCHIPS-1:0]     ce_sel;

   assign wb_chip    = wb_adr_i[ADDRBITS+CSBITS-1:ADDRBITS];
   // Index space may exceed NCHIPS when NCHIPS is not a power of two.
   assign chip_ok    = 32'(wb_chip) < 32'(NCHIPS);
   assign wb_stall_o = (state != S_IDLE);
   assign accept     = (state == S_IDLE) & wb_cyc_i & wb_stb_i;
   assign abort      = (state != S_IDLE) & (~wb_cyc_i | wb_err_i);
   // An abort arriving in the ACK cycle suppresses the acknowledge.
   assign wb_ack_o   = (state == S_ACK) & wb_cyc_i & ~wb_err_i;
   assign strb_last  = we_q ? 32'(TSTRB_WR - 1) : 32'(TSTRB_RD - 1);

   // Per-chip ready select and CE decode for the latched chip index.
   always_comb begin
      ry_sel = 1'b0;
      ce_sel = '1;
      for (int i = 0; i < NCHIPS; i++) begin
         if (32'(chip_q) == 32'(i)) begin
            ry_sel    = nor_ry_i[i];
            ce_sel[i] = 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      tmo_hit   = 1'b0;
      if (abort) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state_nxt = chip_ok ? S_RYWAIT : S_ACK;
                  cnt_nxt   = '0;
               end
            end
            S_RYWAIT: begin
               if (ry_sel) begin
                  state_nxt = S_SETUP;
                  cnt_nxt   = '0;
               end else if (cnt == 32'(RY_TIMEOUT - 1)) begin
                  state_nxt = S_ACK;
                  tmo_hit   = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 32'd1;
               end
            end
            S_SETUP: begin
               if (cnt == 32'(TSETUP - 1)) begin
                  state_nxt = S_STROBE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 32'd1;
               end
            end
            S_STROBE: begin
               if (cnt == strb_last) begin
                  state_nxt = S_HOLD;
                  cnt_nxt   = '0;
                  capture   = ~we_q;
               end else begin
                  cnt_nxt = cnt + 32'd1;
               end
            end
            S_HOLD: begin
               if (cnt == 32'(THOLD - 1)) begin
                  state_nxt = S_ACK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 32'd1;
               end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= S_IDLE;
         cnt         <= '0;
         adr_q       <= '0;
         chip_q      <= '0;
         dat_q       <= '0;
         we_q        <= 1'b0;
         wb_dat_o    <= '0;
         timeout_o   <= 1'b0;
         nor_ce_o    <= '1;
         nor_oe_o    <= 1'b1;
         nor_we_o    <= 1'b1;
         nor_data_oe <= 1'b0;
         nor_addr_o  <= '0;
         nor_data_o  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            adr_q     <= wb_adr_i[ADDRBITS-1:0];
            chip_q    <= wb_chip;
            dat_q     <= wb_dat_i;
            we_q      <= wb_we_i;
            timeout_o <= 1'b0;
            if (!chip_ok) wb_dat_o <= '1;
         end
         if (tmo_hit) begin
            timeout_o <= 1'b1;
            wb_dat_o  <= '1;
         end
         if (capture) wb_dat_o <= nor_data_i;

         // Pins are registered from the next state so they line up with
         // the state the FSM is in during the following cycle.
         nor_ce_o    <= '1;
         nor_oe_o    <= 1'b1;
         nor_we_o    <= 1'b1;
         nor_data_oe <= 1'b0;
         if (state_nxt inside {S_SETUP, S_STROBE, S_HOLD}) begin
            nor_ce_o   <= ce_sel;
            nor_addr_o <= adr_q;
            if (we_q) begin
               nor_data_oe <= 1'b1;
               nor_data_o  <= dat_q;
            end
         end
         if (state_nxt == S_STROBE) begin
            if (we_q) nor_we_o <= 1'b0;
            else      nor_oe_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_nor_multibus.sv
// Self-checking bench for wb_nor_multibus (3 chips so one chip index is
// unpopulated, short ready timeout so timeouts are reachable).
module tb_wb_nor_multibus;

   localparam int AB = 26, DB = 16, NC = 3, CSB = 2;
   localparam int TS = 1, TRD = 7, TWR = 4, TH = 1, RYTO = 24;

   logic                wb_clk_i = 1'b0;
   logic                wb_rst_i = 1'b1;
   logic [AB+CSB-1:0]   wb_adr_i = '0;
   logic [DB-1:0]       wb_dat_i = '0;
   logic                wb_we_i  = 1'b0;
   logic                wb_cyc_i = 1'b0;
   logic                wb_stb_i = 1'b0;
   logic                wb_err_i = 1'b0;
   logic                wb_ack_o, wb_stall_o, timeout_o;
   logic [DB-1:0]       wb_dat_o;
   logic [NC-1:0]       nor_ry_i = '1;
   logic [DB-1:0]       nor_data_i = '0;
   logic [DB-1:0]       nor_data_o;
   logic                nor_data_oe;
   logic [AB-1:0]       nor_addr_o;
   logic [NC-1:0]       nor_ce_o;
   logic                nor_oe_o, nor_we_o;

   wb_nor_multibus #(
      .ADDRBITS(AB), .DATABITS(DB), .NCHIPS(NC), .TSETUP(TS), .TSTRB_RD(TRD),
      .TSTRB_WR(TWR), .THOLD(TH), .RY_TIMEOUT(RYTO)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
      .wb_dat_i(wb_dat_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i), .wb_err_i(wb_err_i), .wb_ack_o(wb_ack_o),
      .wb_stall_o(wb_stall_o), .wb_dat_o(wb_dat_o), .timeout_o(timeout_o),
      .nor_ry_i(nor_ry_i), .nor_data_i(nor_data_i), .nor_data_o(nor_data_o),
      .nor_data_oe(nor_data_oe), .nor_addr_o(nor_addr_o), .nor_ce_o(nor_ce_o),
      .nor_oe_o(nor_oe_o), .nor_we_o(nor_we_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int            nvec = 0, nerr = 0;
   logic [DB-1:0] dat_model = '0;

   // Observed / expected summary of one transfer.
   typedef struct packed {
      logic [7:0]    lat;      // cycles from accept edge to ack cycle
      logic [7:0]    oe_lo;
      logic [7:0]    we_lo;
      logic [7:0]    ce_lo;
      logic [7:0]    doe_hi;
      logic          viol;     // pin-protocol violation seen
      logic          idle_ok;  // idle, no ack, the cycle after ack
      logic          tmo;
      logic [DB-1:0] dat;
   } obs_t;

   // Reference: what a transfer should look like, from the chip index,
   // direction and the number of not-ready cycles presented.
   function automatic obs_t model(int chip, bit we, int dly, logic [DB-1:0] rdv);
      obs_t e;
      int   act;
      e = '0;
      e.idle_ok = 1'b1;
      if (chip >= NC) begin
         e.lat = 8'd1;
         e.dat = '1;
      end else if (dly >= RYTO) begin
         e.lat = 8'(1 + RYTO);
         e.dat = '1;
         e.tmo = 1'b1;
      end else begin
         act      = we ? TWR : TRD;
         e.lat    = 8'(2 + dly + TS + act + TH);
         e.oe_lo  = we ? 8'd0 : 8'(TRD);
         e.we_lo  = we ? 8'(TWR) : 8'd0;
         e.ce_lo  = 8'(TS + act + TH);
         e.doe_hi = we ? 8'(TS + act + TH) : 8'd0;
         e.dat    = we ? dat_model : rdv;
      end
      return e;
   endfunction

   // Issue one request (DUT idle, called at a negedge) and watch the pins
   // until ack. Ready is held low for the first dly cycles after accept.
   // rdv returns the value the bench drove during the last OE-low cycle.
   task automatic run_txn(input int chip, input bit we, input logic [AB-1:0] adr,
                          input logic [DB-1:0] wd, input int dly, input bit fix,
                          input logic [DB-1:0] fixv, output obs_t o,
                          output logic [DB-1:0] rdv);
      logic [NC-1:0] ce_exp;
      ce_exp = '1;
      if (chip < NC) ce_exp[chip] = 1'b0;
      o   = '0;
      rdv = '0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_err_i = 1'b0;
      wb_adr_i = {CSB'(chip), adr}; wb_dat_i = wd;
      @(posedge wb_clk_i);
      for (int k = 1; k <= 80; k++) begin
         @(negedge wb_clk_i);
         if (k == 1) wb_stb_i = 1'b0;
         if (!nor_oe_o)    o.oe_lo  = o.oe_lo + 8'd1;
         if (!nor_we_o)    o.we_lo  = o.we_lo + 8'd1;
         if (nor_data_oe)  o.doe_hi = o.doe_hi + 8'd1;
         if (nor_ce_o != '1) begin
            o.ce_lo = o.ce_lo + 8'd1;
            if (nor_ce_o != ce_exp || nor_addr_o != adr) o.viol = 1'b1;
         end
         if (!nor_oe_o && !nor_we_o) o.viol = 1'b1;
         if ($countones(~nor_ce_o) > 1) o.viol = 1'b1;
         if (nor_data_oe && (!nor_oe_o || !we || nor_data_o != wd)) o.viol = 1'b1;
         if (!wb_stall_o) o.viol = 1'b1;
         if (wb_ack_o) begin
            o.lat = 8'(k);
            o.dat = wb_dat_o;
            o.tmo = timeout_o;
            if (nor_ce_o != '1 || nor_data_oe) o.viol = 1'b1;
            break;
         end
         nor_ry_i   = (k > dly) ? '1 : '0;
         nor_data_i = (!nor_oe_o && fix) ? fixv : DB'($urandom);
         if (!nor_oe_o) rdv = nor_data_i;
      end
      wb_cyc_i = 1'b0;
      nor_ry_i = '1;
      @(negedge wb_clk_i);
      o.idle_ok = !wb_ack_o && !wb_stall_o && (nor_ce_o == '1);
   endtask

   task automatic test_reset;
      wb_rst_i = 1'b1;
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      nvec++;
      if ({nor_ce_o, nor_oe_o, nor_we_o, nor_data_oe} !== {3'b111, 1'b1, 1'b1, 1'b0}) begin
         nerr++;
         $display("FAIL reset_strobes: got %b want 111110", {nor_ce_o, nor_oe_o, nor_we_o, nor_data_oe});
      end
      nvec++;
      if ({nor_addr_o, nor_data_o} !== '0) begin
         nerr++;
         $display("FAIL reset_bus: got addr %h data %h want 0/0", nor_addr_o, nor_data_o);
      end
      nvec++;
      if ({wb_ack_o, wb_stall_o, timeout_o, wb_dat_o} !== '0) begin
         nerr++;
         $display("FAIL reset_wb: got ack %b stall %b tmo %b dat %h want all 0",
                  wb_ack_o, wb_stall_o, timeout_o, wb_dat_o);
      end
      wb_rst_i  = 1'b0;
      dat_model = '0;
      @(negedge wb_clk_i);
   endtask

   // Directed corners: plain read/write, 20-cycle ready wait, the last
   // wait length before timeout, timeout, timeout clear, unpopulated chip.
   task automatic test_directed;
      int            ch[7] = '{1, 0, 0, 2, 2, 0, 3};
      bit            wr[7] = '{0, 1, 0, 0, 0, 0, 1};
      int            dl[7] = '{0, 0, 20, RYTO - 1, RYTO, 0, 0};
      logic [AB-1:0] ad[7] = '{26'h0001234, 26'h3FFFFFF, 26'h0000010, 26'h2AAAAAA,
                               26'h1555555, 26'h0000000, 26'h00000FF};
      logic [DB-1:0] wd[7] = '{16'h0000, 16'hA5A5, 16'h1111, 16'h2222,
                               16'h3333, 16'h4444, 16'h5555};
      obs_t o, e;
      logic [DB-1:0] rdv;
      for (int i = 0; i < 7; i++) begin
         run_txn(ch[i], wr[i], ad[i], wd[i], dl[i], i == 0, 16'hBEEF, o, rdv);
         e = model(ch[i], wr[i], dl[i], rdv);
         if (i == 0) e.dat = 16'hBEEF;
         nvec++;
         if (o !== e) begin
            nerr++;
            $display("FAIL directed_%0d: got %h want %h", i, o, e);
         end
         dat_model = e.dat;
      end
   endtask

   task automatic test_random;
      obs_t o, e;
      logic [DB-1:0] rdv;
      int chip, dly, r;
      bit we;
      for (int i = 0; i < 24; i++) begin
         chip = $urandom_range(0, 3);
         we   = 1'($urandom_range(0, 1));
         r    = $urandom_range(0, 9);
         if (r < 6)      dly = $urandom_range(0, 3);
         else if (r < 8) dly = $urandom_range(18, RYTO - 1);
         else            dly = RYTO + $urandom_range(0, 3);
         run_txn(chip, we, AB'($urandom), DB'($urandom), dly, 1'b0, '0, o, rdv);
         e = model(chip, we, dly, rdv);
         nvec++;
         if (o !== e) begin
            nerr++;
            $display("FAIL random_%0d (chip %0d we %0d dly %0d): got %h want %h",
                     i, chip, we, dly, o, e);
         end
         dat_model = e.dat;
      end
   endtask

   task automatic test_abort;
      obs_t o, e;
      logic [DB-1:0] rdv;
      int acks;
      bit seen;
      // wb_err_i during the read strobe
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = {2'd0, 26'h0000ABC};
      @(posedge wb_clk_i);
      seen = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge wb_clk_i);
         wb_stb_i = 1'b0;
         if (!nor_oe_o) begin seen = 1'b1; break; end
      end
      nvec++;
      if (!seen) begin
         nerr++;
         $display("FAIL abort_err_strobe: got no OE pulse, want one within 20 cycles");
      end
      wb_err_i = 1'b1;
      @(negedge wb_clk_i);
      nvec++;
      if ({nor_oe_o, nor_we_o, nor_ce_o, nor_data_oe, wb_stall_o, wb_ack_o} !==
          {1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0}) begin
         nerr++;
         $display("FAIL abort_err_idle: got oe %b we %b ce %b doe %b stall %b ack %b want 1 1 111 0 0 0",
                  nor_oe_o, nor_we_o, nor_ce_o, nor_data_oe, wb_stall_o, wb_ack_o);
      end
      wb_err_i = 1'b0;
      wb_cyc_i = 1'b0;
      // cyc dropped while waiting for ready
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = {2'd2, 26'h0000123};
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      wb_stb_i = 1'b0; nor_ry_i = '0;
      acks = 0;
      repeat (2) begin @(negedge wb_clk_i); if (wb_ack_o) acks++; end
      wb_cyc_i = 1'b0;
      @(negedge wb_clk_i);
      if (wb_ack_o) acks++;
      nvec++;
      if (acks != 0 || wb_stall_o !== 1'b0 || wb_dat_o !== dat_model) begin
         nerr++;
         $display("FAIL abort_cyc: got acks %0d stall %b dat %h want 0 0 %h",
                  acks, wb_stall_o, wb_dat_o, dat_model);
      end
      nor_ry_i = '1;
      // normal transfer after the aborts
      run_txn(1, 1'b0, 26'h0000777, '0, 0, 1'b0, '0, o, rdv);
      e = model(1, 1'b0, 0, rdv);
      nvec++;
      if (o !== e) begin
         nerr++;
         $display("FAIL abort_recover: got %h want %h", o, e);
      end
      dat_model = e.dat;
   endtask

   task automatic test_reset_mid;
      int acks;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = {2'd1, 26'h0000042}; wb_dat_i = 16'h5A5A;
      @(posedge wb_clk_i);
      repeat (4) begin @(negedge wb_clk_i); wb_stb_i = 1'b0; end
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      nvec++;
      if ({nor_ce_o, nor_we_o, nor_data_oe, wb_stall_o, wb_ack_o, wb_dat_o} !==
          {3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
         nerr++;
         $display("FAIL reset_mid: got ce %b we %b doe %b stall %b ack %b dat %h want 111 1 0 0 0 0000",
                  nor_ce_o, nor_we_o, nor_data_oe, wb_stall_o, wb_ack_o, wb_dat_o);
      end
      wb_rst_i  = 1'b0;
      dat_model = '0;
      acks = 0;
      repeat (10) begin @(negedge wb_clk_i); if (wb_ack_o) acks++; end
      nvec++;
      if (acks != 0) begin
         nerr++;
         $display("FAIL reset_mid_noack: got %0d acks want 0", acks);
      end
      wb_cyc_i = 1'b0;
      @(negedge wb_clk_i);
   endtask

   // Strobe held high: each request must wait for IDLE, so acks are spaced
   // by the previous transfer's latency plus one idle cycle.
   task automatic test_back_to_back;
      int ch[4] = '{3, 0, 1, 3};
      bit wr[4] = '{0, 1, 0, 1};
      int exp_t[4], got_t[4];
      int t, n;
      obs_t e;
      t = 0;
      for (int i = 0; i < 4; i++) begin
         e = model(ch[i], wr[i], 0, '0);
         t = t + int'(e.lat);
         exp_t[i] = t;
         got_t[i] = -1;
         t = t + 1;
      end
      n = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = wr[0];
      wb_adr_i = {CSB'(ch[0]), 26'h0000100}; wb_dat_i = 16'h0F0F;
      @(posedge wb_clk_i);
      for (int k = 1; k <= 60; k++) begin
         @(negedge wb_clk_i);
         nor_data_i = DB'($urandom);
         if (wb_ack_o) begin
            got_t[n] = k;
            n++;
            if (n == 4) break;
            wb_we_i  = wr[n];
            wb_adr_i = {CSB'(ch[n]), AB'(256 + n)};
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nvec++;
         if (got_t[i] != exp_t[i]) begin
            nerr++;
            $display("FAIL b2b_ack_%0d: got cycle %0d want cycle %0d", i, got_t[i], exp_t[i]);
         end
      end
      @(negedge wb_clk_i);
      nvec++;
      if (wb_dat_o !== 16'hFFFF) begin
         nerr++;
         $display("FAIL b2b_dat: got %h want ffff", wb_dat_o);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/wb_nor_multibus.md
WB_NOR_MULTIBUS -- requirements
Module: wb_nor_multibus

Interface
REQ-001 Parameter ADDRBITS, default 26, NOR word-address width per chip.
REQ-002 Parameter DATABITS, default 16, NOR data width.
REQ-003 Parameter NCHIPS, default 2, number of NOR chips sharing address/data/OE/WE; CSBITS = max(1, clog2(NCHIPS)).
REQ-004 Parameters TSETUP, TSTRB_RD, TSTRB_WR, THOLD, defaults 1, 7, 4, 1, cycle counts, each SHALL be >= 1.
REQ-005 Parameter RY_TIMEOUT, default 1024, maximum ready-wait cycles.
REQ-006 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-007 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-008 wb_adr_i  in  ADDRBITS+CSBITS  [ADDRBITS+CSBITS-1:ADDRBITS] = chip index, low ADDRBITS = word address.
REQ-009 wb_dat_i  in  DATABITS  write data; wb_we_i  in  1  1 = write.
REQ-010 wb_cyc_i, wb_stb_i, wb_err_i  in  1 each  Wishbone pipelined cycle, strobe, master abort.
REQ-011 wb_ack_o, wb_stall_o  out  1 each; wb_dat_o  out  DATABITS  read data.
REQ-012 timeout_o  out  1  sticky ready-timeout flag.
REQ-013 nor_ry_i  in  NCHIPS  per-chip ready/busy#, 1 = ready.
REQ-014 nor_data_i  in  DATABITS; nor_data_o  out  DATABITS; nor_data_oe  out  1 (1 = drive bus).
REQ-015 nor_addr_o  out  ADDRBITS; nor_ce_o  out  NCHIPS, active-low; nor_oe_o, nor_we_o  out  1, active-low.

Function
REQ-016 States SHALL be IDLE, RYWAIT, SETUP, STROBE, HOLD, ACK.
REQ-017 wb_stall_o SHALL be 0 in IDLE and 1 in every other state; a request is accepted when wb_cyc_i & wb_stb_i & !wb_stall_o.
REQ-018 On accept, address, chip index, data and we SHALL be latched and the FSM SHALL enter RYWAIT.
REQ-019 Chip index >= NCHIPS: no CE asserted, FSM goes directly to ACK, wb_dat_o = all ones, writes discarded.
REQ-020 RYWAIT: leave to SETUP in the first cycle nor_ry_i[chip] = 1; counter increments each cycle otherwise.
REQ-021 RYWAIT counter reaching RY_TIMEOUT SHALL set timeout_o, go to ACK with wb_dat_o = all ones, no NOR strobe.
REQ-022 timeout_o SHALL clear on the next accepted request.
REQ-023 SETUP: nor_addr_o = latched address, nor_ce_o[chip] = 0 (others 1), OE/WE = 1; writes also nor_data_oe = 1, nor_data_o = latched data; lasts TSETUP cycles.
REQ-024 STROBE: read drives nor_oe_o = 0 for TSTRB_RD cycles; write drives nor_we_o = 0 for TSTRB_WR cycles; nor_data_oe stays 0 on reads.
REQ-025 Read data SHALL be captured from nor_data_i on the last STROBE cycle into wb_dat_o.
REQ-026 HOLD: OE/WE = 1, CE, address and write data held, THOLD cycles, then ACK.
REQ-027 ACK: wb_ack_o = 1 for exactly one cycle, all CE = 1, nor_data_oe = 0, next state IDLE.
REQ-028 Ready-chip read: ack in cycle T+2+TSETUP+TSTRB_RD+THOLD after accept cycle T (defaults: T+11); write: T+2+TSETUP+TSTRB_WR+THOLD (T+8).
REQ-029 nor_oe_o and nor_we_o SHALL never be 0 simultaneously; at most one nor_ce_o bit SHALL be 0.
REQ-030 nor_data_oe SHALL never be 1 while nor_oe_o = 0.
REQ-031 wb_err_i = 1, or wb_cyc_i = 0, in any non-IDLE state SHALL abort: next cycle IDLE, all strobes/CE = 1, nor_data_oe = 0, no ack.
REQ-032 wb_dat_o SHALL hold its value until the next read capture or timeout/invalid-chip response.
REQ-033 All NOR outputs SHALL be registered (no combinational path from Wishbone inputs to NOR pins).

Reset
REQ-034 While wb_rst_i = 1 at a clock edge: state IDLE, nor_ce_o all 1, nor_oe_o = 1, nor_we_o = 1, nor_data_oe = 0, nor_addr_o = 0, nor_data_o = 0.
REQ-035 Reset also SHALL clear wb_ack_o, wb_stall_o, wb_dat_o, timeout_o and all counters; reset mid-transfer SHALL abandon it without ack.

Verification
REQ-036 Read chip 1 addr 0x0001234, ry = 1, NOR returns 0xBEEF -> nor_ce_o = 2'b01, OE low 7 cycles, ack at T+11, wb_dat_o = 0xBEEF.
REQ-037 Write chip 0 addr 0x3FFFFFF data 0xA5A5 -> nor_ce_o = 2'b10, data_oe high SETUP..HOLD, WE low 4 cycles, ack at T+8.
REQ-038 Read with nor_ry_i[0] low 20 cycles then high -> ack 20 cycles later than REQ-036 timing; timeout_o = 0.
REQ-039 nor_ry_i held low, RY_TIMEOUT = 16 -> no OE/WE pulse, ack with 0xFFFF, timeout_o = 1, cleared on next accept.
REQ-040 wb_err_i pulsed during STROBE of a read -> next cycle OE/CE high, stall 0, no ack; following request completes normally.
REQ-041 NCHIPS = 3, chip index 3 -> no CE asserted, ack at T+1 with 0xFFFF; back-to-back requests each stalled until IDLE.
